button_gesture: RTL and testbench

//   Front-end for the two-button watch UI. Synchronises and debounces two active-low push buttons.

---
 rtl/button_gesture.sv | 209 ++++++++++++++++++++
 tb/tb_button_gesture.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_gesture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : button_gesture
//  Description : Two-button front-end for the watch UI. Synchronises and
//                debounces two active-low push buttons, then classifies each
//                gesture as a short press, a long single-key hold or a
//                two-key chord hold, and reports it as a one-cycle pulse.
//
//  Ports       : clk      - clock
//                rst      - asynchronous active-high reset
//                key_a_n  - raw button A, active-low, asynchronous to clk
//                key_b_n  - raw button B, active-low, asynchronous to clk
//                held_a   - debounced level of A (1 = pressed)
//                held_b   - debounced level of B (1 = pressed)
//                press_a  - pulse: A released before the long-hold time
//                press_b  - pulse: B released before the long-hold time
//                long_a   - pulse: A alone held for the long-hold time
//                long_b   - pulse: B alone held for the long-hold time
//                chord    - pulse: A and B together held for the long-hold time
//
//  Revision    : 1.0 - initial release
// ============================================================================
module button_gesture #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 4000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_a_n,
    input  logic key_b_n,
    output logic held_a,
    output logic held_b,
    output logic press_a,
    output logic press_b,
    output logic long_a,
    output logic long_b,
    output logic chord
);

    localparam int c_DB_CYC   = (CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int c_LONG_CYC = (CLK_HZ / 1000) * LONG_MS;
    localparam int c_DB_W     = $clog2(c_DB_CYC + 1);
    localparam int c_HOLD_W   = $clog2(c_LONG_CYC + 1);

    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(c_DB_CYC - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(c_LONG_CYC - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_SAT  = c_HOLD_W'(c_LONG_CYC);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_A_DN = 3'd1;
    localparam logic [2:0] c_ST_B_DN = 3'd2;
    localparam logic [2:0] c_ST_BOTH = 3'd3;
    localparam logic [2:0] c_ST_REL  = 3'd4;

    logic [1:0] w_key_n;
    logic [1:0] w_held;

    assign w_key_n = {key_b_n, key_a_n};

    // ------------------------------------------------------------------------
    // Per-key synchroniser and debouncer. The sync chain resets to the idle
    // (released) level so a key held through reset is seen as a new press.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            logic [1:0]        r_sync;
            logic [c_DB_W-1:0] r_db_cnt;
            logic              r_held;
            logic              w_pressed;

            assign w_pressed  = ~r_sync[1];
            assign w_held[gi] = r_held;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync   <= 2'b11;
                    r_db_cnt <= '0;
                    r_held   <= 1'b0;
                end else begin
                    r_sync <= {r_sync[0], w_key_n[gi]};
                    if (w_pressed == r_held) begin
                        r_db_cnt <= '0;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_held   <= ~r_held;
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign held_a = w_held[0];
    assign held_b = w_held[1];

    // ------------------------------------------------------------------------
    // Gesture classifier. One shared hold counter, cleared on every state
    // entry. Key changes take priority over the hold timeout in the same
    // cycle, so a release coinciding with the timeout is treated as a release.
    // ------------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_inc;

    assign w_hold_inc = (r_hold == c_HOLD_SAT) ? r_hold : r_hold + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_hold  <= '0;
            press_a <= 1'b0;
            press_b <= 1'b0;
            long_a  <= 1'b0;
            long_b  <= 1'b0;
            chord   <= 1'b0;
        end else begin
            press_a <= 1'b0;
            press_b <= 1'b0;
            long_a  <= 1'b0;
            long_b  <= 1'b0;
            chord   <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    r_hold <= '0;
                    if (held_a && held_b) begin
                        r_state <= c_ST_BOTH;
                    end else if (held_a) begin
                        r_state <= c_ST_A_DN;
                    end else if (held_b) begin
                        r_state <= c_ST_B_DN;
                    end
                end

                c_ST_A_DN: begin
                    if (!held_a && held_b) begin
                        // Hand-over from A to B in one cycle: ambiguous, drop it.
                        r_state <= c_ST_REL;
                        r_hold  <= '0;
                    end else if (held_b) begin
                        r_state <= c_ST_BOTH;
                        r_hold  <= '0;
                    end else if (!held_a) begin
                        press_a <= 1'b1;
                        r_state <= c_ST_IDLE;
                        r_hold  <= '0;
                    end else if (r_hold == c_HOLD_LAST) begin
                        long_a  <= 1'b1;
                        r_state <= c_ST_REL;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= w_hold_inc;
                    end
                end

                c_ST_B_DN: begin
                    if (!held_b && held_a) begin
                        r_state <= c_ST_REL;
                        r_hold  <= '0;
                    end else if (held_a) begin
                        r_state <= c_ST_BOTH;
                        r_hold  <= '0;
                    end else if (!held_b) begin
                        press_b <= 1'b1;
                        r_state <= c_ST_IDLE;
                        r_hold  <= '0;
                    end else if (r_hold == c_HOLD_LAST) begin
                        long_b  <= 1'b1;
                        r_state <= c_ST_REL;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= w_hold_inc;
                    end
                end

                c_ST_BOTH: begin
                    if (!held_a || !held_b) begin
                        // Chord aborted before the hold time: no event.
                        r_state <= c_ST_REL;
                        r_hold  <= '0;
                    end else if (r_hold == c_HOLD_LAST) begin
                        chord   <= 1'b1;
                        r_state <= c_ST_REL;
                        r_hold  <= '0;
                    end else begin
                        r_hold <= w_hold_inc;
                    end
                end

                c_ST_REL: begin
                    r_hold <= '0;
                    if (!held_a && !held_b) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_gesture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_button_gesture
//  Description : Self-checking bench for button_gesture with small timing
//                parameters (debounce 5 cycles, long hold 20 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_gesture;

    logic clk = 1'b0;
    logic rst;
    logic key_a_n, key_b_n;
    logic held_a, held_b, press_a, press_b, long_a, long_b, chord;

    always #5 clk = ~clk;

    button_gesture #(
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (5),
        .LONG_MS     (20)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_a_n (key_a_n),
        .key_b_n (key_b_n),
        .held_a  (held_a),
        .held_b  (held_b),
        .press_a (press_a),
        .press_b (press_b),
        .long_a  (long_a),
        .long_b  (long_b),
        .chord   (chord)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Cumulative event counts, sampled shortly after each rising edge.
    int cnt_pa = 0, cnt_pb = 0, cnt_la = 0, cnt_lb = 0, cnt_ch = 0, cnt_multi = 0;
    int b_pa, b_pb, b_la, b_lb, b_ch;

    always begin
        @(posedge clk);
        #3;
        if (press_a) cnt_pa++;
        if (press_b) cnt_pb++;
        if (long_a)  cnt_la++;
        if (long_b)  cnt_lb++;
        if (chord)   cnt_ch++;
        if ($countones({press_a, press_b, long_a, long_b, chord}) > 1) cnt_multi++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return held_a;
            1:       return held_b;
            2:       return press_a;
            3:       return press_b;
            4:       return long_a;
            5:       return long_b;
            default: return chord;
        endcase
    endfunction

    // Waits (bounded) for a signal to reach a level; k is the number of
    // falling edges taken, so a change on the n-th rising edge gives k = n.
    task automatic wait_lvl(input string name, input int sel, input logic lvl,
                            input int max, output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (sig(sel) !== lvl && k < max);
        if (sig(sel) !== lvl) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0b after %0d cycles, expected %0b",
                     name, sig(sel), k, lvl);
        end
    endtask

    task automatic snap();
        b_pa = cnt_pa; b_pb = cnt_pb; b_la = cnt_la; b_lb = cnt_lb; b_ch = cnt_ch;
    endtask

    task automatic check_deltas(input string tag, input int pa, input int pb,
                                input int la, input int lb, input int ch);
        check({tag, " press_a"}, cnt_pa - b_pa, pa);
        check({tag, " press_b"}, cnt_pb - b_pb, pb);
        check({tag, " long_a"},  cnt_la - b_la, la);
        check({tag, " long_b"},  cnt_lb - b_lb, lb);
        check({tag, " chord"},   cnt_ch - b_ch, ch);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        key_a_n = 1'b1;
        key_b_n = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    typedef struct {
        logic a_n;
        logic b_n;
        int   cyc;
        logic ha;
        logic hb;
        int   pa, pb, la, lb, ch;
    } vec_t;

    vec_t tbl[14];

    initial begin : watchdog
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        int k;

        // Each row holds the keys for cyc cycles, then checks levels and the
        // events raised during that segment. Debounce edge = 7 cycles; long
        // hold fires 21 cycles after the debounced rise.
        //          a_n   b_n   cyc ha    hb    pa pb la lb ch
        tbl[0]  = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1,  8, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 1, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 30, 1'b0, 1'b1, 0, 0, 0, 1, 0};
        tbl[4]  = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 30, 1'b1, 1'b1, 0, 0, 0, 0, 1};
        tbl[6]  = '{1'b1, 1'b0, 10, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        tbl[7]  = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1'b0, 1'b0, 15, 1'b1, 1'b1, 0, 0, 0, 0, 0};
        tbl[9]  = '{1'b1, 1'b0, 10, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        tbl[10] = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 0, 0, 0, 0, 0};
        tbl[11] = '{1'b0, 1'b1, 12, 1'b1, 1'b0, 0, 0, 0, 0, 0};
        tbl[12] = '{1'b0, 1'b0, 10, 1'b1, 1'b1, 0, 0, 0, 0, 0};
        tbl[13] = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 0, 0, 0, 0, 0};

        do_reset();
        check("reset held_a",  held_a,  0);
        check("reset held_b",  held_b,  0);
        check("reset press_a", press_a, 0);
        check("reset press_b", press_b, 0);
        check("reset long_a",  long_a,  0);
        check("reset long_b",  long_b,  0);
        check("reset chord",   chord,   0);

        for (int i = 0; i < 14; i++) begin
            snap();
            key_a_n = tbl[i].a_n;
            key_b_n = tbl[i].b_n;
            tick(tbl[i].cyc);
            check($sformatf("vec%0d held_a", i), held_a, tbl[i].ha);
            check($sformatf("vec%0d held_b", i), held_b, tbl[i].hb);
            check_deltas($sformatf("vec%0d", i),
                         tbl[i].pa, tbl[i].pb, tbl[i].la, tbl[i].lb, tbl[i].ch);
        end

        // Bounce: 10 toggles two cycles apart, then held low.
        do_reset();
        snap();
        for (int i = 0; i < 10; i++) begin
            key_a_n = ~key_a_n;
            tick(2);
        end
        check("bounce held_a during bounce", held_a, 0);
        key_a_n = 1'b0;
        wait_lvl("bounce held_a rise", 0, 1'b1, 20, k);
        check("bounce held_a latency", k, 7);
        check_deltas("bounce", 0, 0, 0, 0, 0);

        // Short A: release 10 cycles after the debounced rise.
        snap();
        tick(10);
        key_a_n = 1'b1;
        wait_lvl("shortA held_a fall", 0, 1'b0, 20, k);
        check("shortA fall latency", k, 7);
        @(negedge clk);
        check("shortA press_a after fall", press_a, 1);
        tick(3);
        check_deltas("shortA", 1, 0, 0, 0, 0);

        // Long B: held 30 cycles past the debounced rise.
        snap();
        key_b_n = 1'b0;
        wait_lvl("longB held_b rise", 1, 1'b1, 20, k);
        wait_lvl("longB long_b", 5, 1'b1, 40, k);
        check("longB long_b latency", k, 21);
        tick(9);
        key_b_n = 1'b1;
        wait_lvl("longB held_b fall", 1, 1'b0, 20, k);
        tick(3);
        check_deltas("longB", 0, 0, 0, 1, 0);

        // Chord: A then B three cycles later, both held 25 cycles.
        snap();
        key_a_n = 1'b0;
        tick(3);
        key_b_n = 1'b0;
        wait_lvl("chord held_b rise", 1, 1'b1, 20, k);
        check("chord held_a with held_b", held_a, 1);
        wait_lvl("chord pulse", 6, 1'b1, 40, k);
        check("chord latency", k, 21);
        tick(4);
        key_a_n = 1'b1;
        tick(10);
        key_b_n = 1'b1;
        wait_lvl("chord held_b fall", 1, 1'b0, 20, k);
        tick(3);
        check_deltas("chord", 0, 0, 0, 0, 1);

        // Aborted chord, then a short B press.
        snap();
        key_a_n = 1'b0;
        key_b_n = 1'b0;
        tick(8);
        key_b_n = 1'b1;
        wait_lvl("abort held_b fall", 1, 1'b0, 20, k);
        tick(5);
        key_a_n = 1'b1;
        wait_lvl("abort held_a fall", 0, 1'b0, 20, k);
        tick(3);
        check_deltas("abort", 0, 0, 0, 0, 0);
        snap();
        key_b_n = 1'b0;
        wait_lvl("abortB held_b rise", 1, 1'b1, 20, k);
        tick(5);
        key_b_n = 1'b1;
        wait_lvl("abortB held_b fall", 1, 1'b0, 20, k);
        @(negedge clk);
        check("abortB press_b after fall", press_b, 1);
        tick(3);
        check_deltas("abortB", 0, 1, 0, 0, 0);

        // Reset at hold count 15 in A_DN with A still held.
        key_a_n = 1'b0;
        wait_lvl("rst held_a rise", 0, 1'b1, 20, k);
        tick(16);
        rst = 1'b1;
        #1;
        check("rst held_a",  held_a,  0);
        check("rst held_b",  held_b,  0);
        check("rst press_a", press_a, 0);
        check("rst long_a",  long_a,  0);
        check("rst chord",   chord,   0);
        tick(2);
        rst = 1'b0;
        snap();
        wait_lvl("rst held_a re-rise", 0, 1'b1, 20, k);
        check("rst held_a re-rise latency", k, 7);
        wait_lvl("rst long_a", 4, 1'b1, 40, k);
        check("rst long_a latency", k, 21);
        key_a_n = 1'b1;
        wait_lvl("rst held_a fall", 0, 1'b0, 20, k);
        tick(3);
        check_deltas("rst", 0, 0, 1, 0, 0);

        check("one-hot events", cnt_multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
